// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// apb_req_arbiter : two-requester round-robin APB master with slave decode,
//                   SETUP/ACCESS sequencing and a wait-state timeout
// Rev 1.0
// ============================================================================
module apb_req_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SEL_LSB = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_done,
  output logic                req_err,
  output logic [DATA_W-1:0]   req_rdata,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic                PWRITE,
  output logic [3:0]          PSEL,
  output logic                PENABLE,
  input  logic [DATA_W-1:0]   SPI_PRDATA,
  input  logic [DATA_W-1:0]   GPIO_PRDATA,
  input  logic [DATA_W-1:0]   ICPIT_PRDATA,
  input  logic [DATA_W-1:0]   UART_PRDATA,
  input  logic                SPI_PREADY,
  input  logic                GPIO_PREADY,
  input  logic                ICPIT_PREADY,
  input  logic                UART_PREADY
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SETUP  = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  logic [1:0]        r_state;
  logic              r_gnt;
  logic              r_last_gnt;
  logic [1:0]        r_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_pwrite;
  logic [3:0]        r_psel;
  logic              r_penable;
  logic [1:0]        r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_write;
  logic [2:0]        w_field;
  logic [3:0]        w_psel_dec;
  logic              w_pready;
  logic [DATA_W-1:0] w_prdata;
  logic [CNT_W-1:0]  w_cnt_next;

  always_comb begin
    // On a tie the requester that did not win last time is granted
    w_gnt      = (req_valid == 2'b11) ? ~r_last_gnt : req_valid[1];
    w_addr     = w_gnt ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    w_wdata    = w_gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    w_write    = w_gnt ? req_write[1] : req_write[0];
    w_field    = w_addr[SEL_LSB+2:SEL_LSB];
    w_psel_dec = 4'b0001 << w_field[1:0];
    w_cnt_next = r_cnt + CNT_W'(1);
    w_pready   = SPI_PREADY;
    w_prdata   = SPI_PRDATA;
    case (r_sel)
      2'd1: begin w_pready = GPIO_PREADY;  w_prdata = GPIO_PRDATA;  end
      2'd2: begin w_pready = ICPIT_PREADY; w_prdata = ICPIT_PRDATA; end
      2'd3: begin w_pready = UART_PREADY;  w_prdata = UART_PRDATA;  end
      default: begin w_pready = SPI_PREADY; w_prdata = SPI_PRDATA; end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= c_IDLE;
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_sel      <= 2'd0;
      r_cnt      <= '0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_pwrite   <= 1'b0;
      r_psel     <= 4'b0000;
      r_penable  <= 1'b0;
      r_done     <= 2'b00;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        c_IDLE: begin
          if (|req_valid) begin
            r_gnt    <= w_gnt;
            r_paddr  <= w_addr;
            r_pwdata <= w_wdata;
            r_pwrite <= w_write;
            r_sel    <= w_field[1:0];
            if (!w_field[2]) begin
              r_psel  <= w_psel_dec;
              r_state <= c_SETUP;
            end else begin
              // Unmapped window: answer with an error, never touch the bus
              r_done  <= w_gnt ? 2'b10 : 2'b01;
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= c_DONE;
            end
          end
        end
        c_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= c_ACCESS;
        end
        c_ACCESS: begin
          r_cnt <= w_cnt_next;
          if (w_pready) begin
            r_done    <= r_gnt ? 2'b10 : 2'b01;
            r_err     <= 1'b0;
            r_rdata   <= r_pwrite ? '0 : w_prdata;
            r_psel    <= 4'b0000;
            r_penable <= 1'b0;
            r_state   <= c_DONE;
          end else if (w_cnt_next == c_TIMEOUT) begin
            r_done    <= r_gnt ? 2'b10 : 2'b01;
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_psel    <= 4'b0000;
            r_penable <= 1'b0;
            r_state   <= c_DONE;
          end
        end
        c_DONE: begin
          r_last_gnt <= r_gnt;
          r_cnt      <= '0;
          r_err      <= 1'b0;
          r_rdata    <= '0;
          r_state    <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign req_done  = r_done;
  assign req_err   = r_err;
  assign req_rdata = r_rdata;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PWRITE    = r_pwrite;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_apb_req_arbiter : directed bench with a transaction-level expectation model
// Rev 1.0
// ============================================================================
module tb_apb_req_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SL   = 12;
  localparam int TO   = 16;
  localparam int NCYC = 2048;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_done;
  logic          req_err;
  logic [DW-1:0] req_rdata;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE;
  logic [3:0]    PSEL;
  logic          PENABLE;

  // Slave responders: per-slave wait count (-1 = never ready) and read data
  logic [DW-1:0] srdata [4];
  int            waits [4];
  logic          idle_rdy;
  logic [3:0]    rdy;
  int            acc_cnt = 0;

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SEL_LSB(SL), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .SPI_PRDATA(srdata[0]), .GPIO_PRDATA(srdata[1]), .ICPIT_PRDATA(srdata[2]), .UART_PRDATA(srdata[3]),
    .SPI_PREADY(rdy[0]), .GPIO_PREADY(rdy[1]), .ICPIT_PREADY(rdy[2]), .UART_PREADY(rdy[3])
  );

  always #5 PCLK = ~PCLK;

  always_comb begin
    rdy = 4'b0000;
    for (int s = 0; s < 4; s++)
      rdy[s] = PSEL[s] ? (PENABLE && waits[s] >= 0 && acc_cnt >= waits[s]) : idle_rdy;
  end

  always @(posedge PCLK) begin
    if (PSEL != 4'b0000 && PENABLE && (PSEL & rdy) == 4'b0000) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Per-cycle expectations; cycles not written by the model are bus-idle
  logic [3:0]    e_psel  [NCYC];
  logic          e_pen   [NCYC];
  logic [1:0]    e_done  [NCYC];
  logic          e_err   [NCYC];
  logic [DW-1:0] e_rdata [NCYC];
  logic          e_bus   [NCYC];
  logic [AW-1:0] e_addr  [NCYC];
  logic          e_wr    [NCYC];
  logic [DW-1:0] e_wd    [NCYC];

  int            m_last_gnt = 1;
  logic [AW-1:0] m_addr [2];
  logic          m_wr   [2];
  logic [DW-1:0] m_wd   [2];

  task automatic set_exp(input int c, input logic [3:0] ps, input logic pen, input logic [1:0] dn,
                         input logic er, input logic [DW-1:0] rd, input int g);
    e_psel[c] = ps; e_pen[c] = pen; e_done[c] = dn; e_err[c] = er; e_rdata[c] = rd;
    e_bus[c] = 1'b1; e_addr[c] = m_addr[g]; e_wr[c] = m_wr[g]; e_wd[c] = m_wd[g];
  endtask

  // Whole-transaction expectation from decode, slave wait count and timeout
  task automatic expect_txn(input int c0, input int g, output int lat);
    logic [AW-1:0] a;
    logic [2:0]    f;
    logic [1:0]    dn;
    logic [3:0]    one;
    logic [3:0]    ps;
    logic          er;
    logic [DW-1:0] rd;
    int            s;
    int            acc;
    a   = m_addr[g];
    f   = a[SL+2:SL];
    dn  = (g == 1) ? 2'b10 : 2'b01;
    one = 4'b0001;
    if (f[2]) begin
      set_exp(c0 + 1, 4'b0000, 1'b0, dn, 1'b1, '0, g);
      lat = 1;
    end else begin
      s  = int'(f[1:0]);
      ps = one << s;
      if (waits[s] < 0 || waits[s] >= TO) begin
        acc = TO; er = 1'b1; rd = '0;
      end else begin
        acc = waits[s] + 1; er = 1'b0; rd = m_wr[g] ? '0 : srdata[s];
      end
      set_exp(c0 + 1, ps, 1'b0, 2'b00, 1'b0, '0, g);
      for (int k = 0; k < acc; k++) set_exp(c0 + 2 + k, ps, 1'b1, 2'b00, 1'b0, '0, g);
      set_exp(c0 + 2 + acc, 4'b0000, 1'b0, dn, er, rd, g);
      lat = acc + 2;
    end
    m_last_gnt = g;
  endtask

  function automatic int pick();
    if (req_valid == 2'b11) return 1 - m_last_gnt;
    return req_valid[1] ? 1 : 0;
  endfunction

  always @(negedge PCLK) begin
    if (mon_en) begin
      check("PSEL", PSEL, e_psel[cyc]);
      check("PENABLE", PENABLE, e_pen[cyc]);
      check("req_done", req_done, e_done[cyc]);
      if (e_done[cyc] != 2'b00) begin
        check("req_err", req_err, e_err[cyc]);
        check("req_rdata", req_rdata, e_rdata[cyc]);
      end
      if (e_bus[cyc]) begin
        check("PADDR", PADDR, e_addr[cyc]);
        check("PWRITE", PWRITE, e_wr[cyc]);
        check("PWDATA", PWDATA, e_wd[cyc]);
      end
    end
  end

  // Observation log used by the literal checks
  logic [3:0]    ps_log  [NCYC];
  logic          pen_log [NCYC];
  logic          done_log [64];
  int            done_cnt = 0;
  int            last_done_cyc = 0;
  logic [1:0]    last_done_vec = 2'b00;
  logic          last_err = 1'b0;
  logic [DW-1:0] last_rdata = '0;

  always @(negedge PCLK) begin
    ps_log[cyc]  <= PSEL;
    pen_log[cyc] <= PENABLE;
    if (req_done != 2'b00) begin
      if (done_cnt < 64) done_log[done_cnt] <= req_done[1];
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
      last_done_vec <= req_done;
      last_err      <= req_err;
      last_rdata    <= req_rdata;
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic launch(input int g, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_addr[g] = a; m_wr[g] = wr; m_wd[g] = d;
    req_write[g] = wr;
    req_addr[g*AW +: AW]  = a;
    req_wdata[g*DW +: DW] = d;
    req_valid[g] = 1'b1;
  endtask

  task automatic run_txn(output int c0, output int lat, output int g);
    c0 = cyc;
    g  = pick();
    expect_txn(c0, g, lat);
    repeat (lat + 1) step();
  endtask

  task automatic run_solo(input int g, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int c0, output int lat);
    int gg;
    launch(g, wr, a, d);
    run_txn(c0, lat, gg);
    req_valid[g] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, lat, g, base, nacc;
    logic [5:0] ord;
    for (int i = 0; i < NCYC; i++) begin
      e_psel[i] = 4'b0000; e_pen[i] = 1'b0; e_done[i] = 2'b00; e_err[i] = 1'b0;
      e_rdata[i] = '0; e_bus[i] = 1'b0; e_addr[i] = '0; e_wr[i] = 1'b0; e_wd[i] = '0;
    end
    // Reset with garbage on every input
    idle_rdy  = 1'b0;
    req_valid = 2'($urandom);
    req_write = 2'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    for (int s = 0; s < 4; s++) begin srdata[s] = $urandom; waits[s] = 0; end
    #12;
    check("rst_PSEL", PSEL, 4'b0000);
    check("rst_PENABLE", PENABLE, 1'b0);
    check("rst_PWRITE", PWRITE, 1'b0);
    check("rst_PADDR", PADDR, 32'h0);
    check("rst_PWDATA", PWDATA, 32'h0);
    check("rst_req_done", req_done, 2'b00);
    check("rst_req_err", req_err, 1'b0);
    check("rst_req_rdata", req_rdata, 32'h0);

    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    srdata[0] = 32'h5AA5_0001; srdata[1] = 32'h6010_0002;
    srdata[2] = 32'h1C17_0003; srdata[3] = 32'hCAFE_F00D;
    @(posedge PCLK); #3 PRESETn = 1'b1;
    step();
    mon_en = 1'b1;
    repeat (20) step();

    // Zero-wait GPIO write from requester 0
    run_solo(0, 1'b1, 32'h0000_1004, 32'h1234_5678, c0, lat);
    check("wr_latency", last_done_cyc - c0, 3);
    check("wr_done_vec", last_done_vec, 2'b01);
    check("wr_err", last_err, 1'b0);
    check("wr_rdata", last_rdata, 32'h0);
    check("wr_setup_psel", ps_log[c0+1], 4'b0010);
    check("wr_setup_pen", pen_log[c0+1], 1'b0);
    check("wr_access_pen", pen_log[c0+2], 1'b1);

    // UART read from requester 1 with two wait states
    waits[3] = 2;
    run_solo(1, 1'b0, 32'h0000_3010, 32'h0, c0, lat);
    check("rd_latency", last_done_cyc - c0, 5);
    check("rd_done_vec", last_done_vec, 2'b10);
    check("rd_rdata", last_rdata, 32'hCAFE_F00D);
    check("rd_err", last_err, 1'b0);
    waits[3] = 0;

    // Both requesters held valid for three transfers each
    waits[0] = 1;
    base = done_cnt;
    launch(0, 1'b1, 32'h0000_1008, 32'hA5A5_0001);
    launch(1, 1'b0, 32'h0000_0020, 32'h0);
    begin
      int pend [2];
      pend[0] = 3; pend[1] = 3;
      while (pend[0] + pend[1] > 0) begin
        run_txn(c0, lat, g);
        pend[g]--;
        if (pend[g] == 0) req_valid[g] = 1'b0;
      end
    end
    ord = 6'b101010;
    check("arb_done_count", done_cnt - base, 6);
    for (int i = 0; i < 6; i++) check("arb_order", done_log[base+i], ord[i]);
    waits[0] = 0;

    // ICPIT never ready; other slaves' PREADY held high must be ignored
    waits[2] = -1;
    idle_rdy = 1'b1;
    run_solo(0, 1'b0, 32'h0000_2000, 32'h0, c0, lat);
    check("to_latency", last_done_cyc - c0, 18);
    check("to_err", last_err, 1'b1);
    check("to_rdata", last_rdata, 32'h0);
    nacc = 0;
    for (int k = c0; k <= c0 + 18; k++) if (pen_log[k]) nacc++;
    check("to_access_cycles", nacc, 16);
    idle_rdy = 1'b0;

    // Unmapped decode field
    run_solo(1, 1'b0, 32'h0000_5000, 32'h0, c0, lat);
    check("um_latency", last_done_cyc - c0, 1);
    check("um_err", last_err, 1'b1);
    check("um_psel", ps_log[c0] | ps_log[c0+1] | ps_log[c0+2], 4'b0000);

    // Reset while in ACCESS
    waits[1] = -1;
    launch(0, 1'b0, 32'h0000_1000, 32'h0);
    c0 = cyc;
    set_exp(c0 + 1, 4'b0010, 1'b0, 2'b00, 1'b0, '0, 0);
    step(); step();
    check("rm_pre_psel", PSEL, 4'b0010);
    check("rm_pre_pen", PENABLE, 1'b1);
    base = done_cnt;
    PRESETn = 1'b0;
    req_valid = 2'b00;
    #1;
    check("rm_psel", PSEL, 4'b0000);
    check("rm_pen", PENABLE, 1'b0);
    check("rm_done", req_done, 2'b00);
    m_last_gnt = 1;
    step(); step();
    #2 PRESETn = 1'b1;
    repeat (12) step();
    check("rm_no_done", done_cnt, base);
    waits[1] = 0;

    // Recovery: requester 0 wins after reset
    run_solo(0, 1'b1, 32'h0000_0004, 32'h0BAD_BEEF, c0, lat);
    check("post_latency", last_done_cyc - c0, 3);
    check("post_done_vec", last_done_vec, 2'b01);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
